// File: rtl/eq_sweep_ctrl.sv
// Exhaustive equivalence sweep: drives every NIN-bit vector to two circuits and compares their outputs.
// Optional macro EQ_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module eq_sweep_ctrl #(
    parameter int unsigned NIN    = 2,
    parameter int unsigned NOUT   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NIN-1:0]    vec,
    input  logic [NOUT-1:0]   outa,
    input  logic [NOUT-1:0]   outb,
    output logic              busy,
    output logic              done,
    output logic              equiv,
    output logic [NIN-1:0]    fail_vec,
    output logic [NIN:0]      fail_cnt
);

    localparam int unsigned CNT_W = NIN + 1;
    localparam int unsigned SET_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [NIN-1:0]     vec_d;
    logic [NIN-1:0]     fail_vec_d;
    logic [CNT_W-1:0]   fail_cnt_d;
    logic               equiv_d;
    logic               busy_d;
    logic               done_d;
    logic               mismatch;
    logic               last_vec;

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            vec      <= '0;
            fail_vec <= '0;
            fail_cnt <= '0;
            equiv    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            vec      <= vec_d;
            fail_vec <= fail_vec_d;
            fail_cnt <= fail_cnt_d;
            equiv    <= equiv_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        vec_d      = vec;
        fail_vec_d = fail_vec;
        fail_cnt_d = fail_cnt;
        equiv_d    = equiv;
        mismatch   = 1'b0;
        last_vec   = (vec == {NIN{1'b1}});

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = APPLY;
                    settle_d   = '0;
                    vec_d      = '0;
                    fail_vec_d = '0;
                    fail_cnt_d = '0;
                    equiv_d    = 1'b1;
                end
            end
            APPLY: begin
                if (settle_q == SET_W'(SETTLE - 1)) begin
                    state_d  = CMP;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            CMP: begin
                mismatch = (outa != outb);
                settle_d = '0;
                if (mismatch) begin
                    fail_cnt_d = fail_cnt + CNT_W'(1);
                    equiv_d    = 1'b0;
                    if (fail_cnt == '0) begin
                        fail_vec_d = vec;
                    end
                end
`ifdef EQ_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec + NIN'(1);
                end
`else
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec + NIN'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == APPLY) || (state_d == CMP);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_eq_sweep_ctrl.sv
// Randomized bench for eq_sweep_ctrl: truth tables for circuits A and B are checked against a sweep model.
module tb_eq_sweep_ctrl;

    localparam int unsigned NIN    = 3;
    localparam int unsigned NOUT   = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NV     = 1 << NIN;
    localparam int unsigned PER    = SETTLE + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NIN-1:0]    vec;
    logic [NOUT-1:0]   outa;
    logic [NOUT-1:0]   outb;
    logic              busy;
    logic              done;
    logic              equiv;
    logic [NIN-1:0]    fail_vec;
    logic [NIN:0]      fail_cnt;

    logic [NOUT-1:0]   tbl_a [NV];
    logic [NOUT-1:0]   tbl_b [NV];

    int n_tests = 0;
    int n_fail  = 0;

    int exp_total;
    int exp_vec;
    int exp_cnt;
    int exp_fvec;
    int exp_equiv;

    eq_sweep_ctrl #(.NIN(NIN), .NOUT(NOUT), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vec      (vec),
        .outa     (outa),
        .outb     (outb),
        .busy     (busy),
        .done     (done),
        .equiv    (equiv),
        .fail_vec (fail_vec),
        .fail_cnt (fail_cnt)
    );

    assign outa = tbl_a[vec];
    assign outb = tbl_b[vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: equivalent, 1: random differences, 2: all differ, 3: differ at 1 and 2 only
    task automatic make_tables(input int mode);
        for (int i = 0; i < int'(NV); i++) begin
            tbl_a[i] = NOUT'($urandom);
            case (mode)
                0: tbl_b[i] = tbl_a[i];
                1: tbl_b[i] = tbl_a[i] ^ ($urandom_range(0, 1) != 0 ? NOUT'($urandom_range(1, 15)) : NOUT'(0));
                2: tbl_b[i] = tbl_a[i] ^ NOUT'($urandom_range(1, 15));
                default: tbl_b[i] = (i == 1 || i == 2) ? ~tbl_a[i] : tbl_a[i];
            endcase
        end
    endtask

    function automatic int mism_before(input int nvec);
        int n = 0;
        for (int v = 0; v < nvec; v++) if (tbl_a[v] !== tbl_b[v]) n++;
        return n;
    endfunction

    task automatic compute_model();
        int first = -1;
        int cnt = 0;
        for (int v = 0; v < int'(NV); v++) begin
            if (tbl_a[v] !== tbl_b[v]) begin
                if (first < 0) first = v;
                cnt++;
            end
        end
        exp_equiv = (cnt == 0) ? 1 : 0;
        exp_fvec  = (first < 0) ? 0 : first;
`ifdef EQ_STOP_ON_FAIL_EN
        if (first >= 0) begin
            exp_total = (first + 1) * int'(PER);
            exp_vec   = first;
            exp_cnt   = 1;
        end else begin
            exp_total = int'(NV * PER);
            exp_vec   = int'(NV) - 1;
            exp_cnt   = 0;
        end
`else
        exp_total = int'(NV * PER);
        exp_vec   = int'(NV) - 1;
        exp_cnt   = cnt;
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vec"},   32'(vec), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_equiv"}, 32'(equiv), 32'd0);
        check({tag, "_fvec"},  32'(fail_vec), 32'd0);
        check({tag, "_fcnt"},  32'(fail_cnt), 32'd0);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_equiv"}, 32'(equiv), 32'(exp_equiv));
        check({tag, "_vec"},   32'(vec), 32'(exp_vec));
        check({tag, "_fcnt"},  32'(fail_cnt), 32'(exp_cnt));
        check({tag, "_fvec"},  32'(fail_vec), 32'(exp_fvec));
    endtask

    // Cycle c counts from the edge that accepts start; done must rise exactly at c == exp_total.
    task automatic run_sweep(input string tag, input int abort_at, input int glitch_at);
        compute_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= exp_total; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                check_zero({tag, "_abort"});
                return;
            end
            if (c < exp_total) begin
                check({tag, "_run_busy"}, 32'(busy), 32'd1);
                check({tag, "_run_done"}, 32'(done), 32'd0);
                check({tag, "_run_vec"},  32'(vec), 32'(c / int'(PER)));
                check({tag, "_run_fcnt"}, 32'(fail_cnt), 32'(mism_before(c / int'(PER))));
                start = (c == glitch_at) ? 1'b1 : 1'b0;
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
            end else begin
                check_result({tag, "_end"});
            end
        end
    endtask

    task automatic hold_check(input string tag, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check_result({tag, "_hold"});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        make_tables(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        make_tables(0);
        run_sweep("equiv", -1, -1);
        hold_check("equiv", 3);

        make_tables(3);
        run_sweep("diff12", -1, 4);
        hold_check("diff12", 2);

        // restart straight out of DONE
        make_tables(2);
        run_sweep("alldiff", -1, 1);

        make_tables(1);
        run_sweep("abort", 3, -1);
        repeat (2) begin
            @(negedge clk);
            check_zero("abort_idle");
        end

        // start coincident with reset stays idle
        @(negedge clk);
        start = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        check_zero("start_in_reset");
        @(negedge clk);
        check_zero("start_in_reset_after");

        for (int r = 0; r < 6; r++) begin
            make_tables(int'($urandom_range(0, 3)));
            run_sweep("rand", -1, int'($urandom_range(0, 20)));
            hold_check("rand", 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eq_sweep_ctrl.md
EQ_SWEEP_CTRL -- requirements
Module: eq_sweep_ctrl

Interface
REQ-001 SHALL have parameter NIN, default 2: width of the input vector applied to both circuits under test (1..16).
REQ-002 SHALL have parameter NOUT, default 2: width of each compared output bus (1..32).
REQ-003 SHALL have parameter SETTLE, default 1: cycles each vector is held before outputs are sampled (1..255).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  single-cycle sweep request.
REQ-007 SHALL have port vec  out  NIN  input vector driven to both circuit A and circuit B.
REQ-008 SHALL have port outa  in  NOUT  outputs of circuit A.
REQ-009 SHALL have port outb  in  NOUT  outputs of circuit B.
REQ-010 SHALL have port busy  out  1  sweep in progress.
REQ-011 SHALL have port done  out  1  sweep finished; level, held until the next accepted start.
REQ-012 SHALL have port equiv  out  1  valid while done: 1 = no mismatch found.
REQ-013 SHALL have port fail_vec  out  NIN  first mismatching vector; 0 if none.
REQ-014 SHALL have port fail_cnt  out  NIN+1  number of mismatching vectors.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, CMP, DONE.
REQ-016 IDLE or DONE, start=1 -> APPLY; vec=0, fail_cnt=0, fail_vec=0, equiv=1, done=0, settle counter=0.
REQ-017 start SHALL be ignored in APPLY and CMP.
REQ-018 APPLY SHALL hold vec for exactly SETTLE cycles, then go to CMP.
REQ-019 CMP SHALL sample outa and outb for one cycle; outa!=outb is a mismatch.
REQ-020 On a mismatch, fail_cnt SHALL increment and equiv SHALL clear; fail_vec SHALL capture vec only on the first mismatch.
REQ-021 From CMP with vec != 2^NIN-1: vec increments and the FSM returns to APPLY; with vec == 2^NIN-1: go to DONE, with vec left at all-ones (no wrap).
REQ-022 Each vector SHALL take SETTLE+1 cycles; a full sweep takes 2^NIN*(SETTLE+1) cycles from start to done rising.
REQ-023 busy SHALL be 1 exactly in APPLY and CMP; done SHALL be 1 exactly in DONE.
REQ-024 fail_cnt SHALL not overflow; its maximum is 2^NIN, which fits in NIN+1 bits.
REQ-025 Results (equiv, fail_vec, fail_cnt) SHALL be held stable in DONE and IDLE until the next start.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE with vec=0, busy=0, done=0, equiv=0, fail_vec=0, fail_cnt=0.
REQ-027 Reset mid-sweep SHALL abort the sweep; no partial result is reported and start is required again.
REQ-028 Reset SHALL have priority over start in the same cycle.

Configuration
REQ-029 Macro EQ_STOP_ON_FAIL_EN defined: a mismatch in CMP SHALL go directly to DONE with vec frozen at the failing vector and fail_cnt=1.
REQ-030 Macro EQ_STOP_ON_FAIL_EN undefined: the sweep SHALL always cover all 2^NIN vectors and count every mismatch.

Verification
REQ-031 NIN=2, NOUT=2, SETTLE=1; A and B both implement O0=I0|I1, O1=~I1; pulse start -> done after 8 cycles, equiv=1, fail_cnt=0, fail_vec=0.
REQ-032 Same setup, but B has O0=I0&I1 (mismatch at vec 1 and 2), macro off -> equiv=0, fail_cnt=2, fail_vec=1, done after 8 cycles.
REQ-033 Same as REQ-032 with EQ_STOP_ON_FAIL_EN -> done 4 cycles after start, vec=1, fail_vec=1, fail_cnt=1.
REQ-034 SETTLE=3, equivalent circuits -> each vec value held 4 cycles; done after 16 cycles.
REQ-035 rst_n=0 at cycle 3 of a sweep -> next cycle IDLE, all outputs 0; start pulsed during busy -> no effect.
REQ-036 start in DONE -> new sweep from vec=0 with results cleared; start coincident with rst_n=0 -> stays IDLE.
